// File: rtl/stage_mem.sv
// RV32I memory-access stage: splits each load/store into 1, 2 or 4 little-endian
// byte transfers on a req/ack port and stalls the pipeline until the access is done.
module stage_mem (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic [6:0]  opcode_i,
  input  logic [2:0]  func3_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] wdata_i,
  input  logic [4:0]  wd_i,
  input  logic        wreg_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [7:0]  mem_wbyte_o,
  input  logic        mem_ack_i,
  input  logic [7:0]  mem_rbyte_i,
  output logic        stall_req_o,
  output logic [4:0]  wd_o,
  output logic        wreg_o,
  output logic [31:0] wdata_o
);

  localparam logic [6:0] L_OP   = 7'b0000011;
  localparam logic [6:0] S_OP   = 7'b0100011;
  localparam logic [2:0] F3_B   = 3'b000;
  localparam logic [2:0] F3_H   = 3'b001;
  localparam logic [2:0] F3_W   = 3'b010;
  localparam logic [2:0] F3_BU  = 3'b100;
  localparam logic [2:0] F3_HU  = 3'b101;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t      state;
  logic [1:0]  k;
  logic [31:0] rbuf;

  logic        is_lop, is_sop;
  logic        load_ok, store_ok, valid_op;
  logic [1:0]  k_last;
  logic [31:0] load_res;

  assign is_lop   = (opcode_i == L_OP);
  assign is_sop   = (opcode_i == S_OP);
  assign load_ok  = is_lop && (func3_i == F3_B || func3_i == F3_H || func3_i == F3_W ||
                               func3_i == F3_BU || func3_i == F3_HU);
  assign store_ok = is_sop && (func3_i == F3_B || func3_i == F3_H || func3_i == F3_W);
  assign valid_op = load_ok || store_ok;

  // Index of the final byte: 0, 1 or 3 for byte, half and word accesses.
  always_comb begin
    case (func3_i[1:0])
      2'b00:   k_last = 2'd0;
      2'b01:   k_last = 2'd1;
      default: k_last = 2'd3;
    endcase
  end

  always_comb begin
    case (func3_i)
      F3_B:    load_res = {{24{rbuf[7]}}, rbuf[7:0]};
      F3_H:    load_res = {{16{rbuf[15]}}, rbuf[15:0]};
      F3_W:    load_res = rbuf;
      F3_BU:   load_res = {24'b0, rbuf[7:0]};
      F3_HU:   load_res = {16'b0, rbuf[15:0]};
      default: load_res = 32'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      k     <= 2'd0;
      rbuf  <= 32'b0;
    end else if (rdy) begin
      case (state)
        IDLE: begin
          if (valid_op) begin
            state <= ACCESS;
            k     <= 2'd0;
            rbuf  <= 32'b0;
          end
        end
        ACCESS: begin
          if (mem_ack_i) begin
            if (load_ok) rbuf[{k, 3'b000} +: 8] <= mem_rbyte_i;
            if (k == k_last) state <= DONE;
            else             k     <= k + 2'd1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs are combinational off the state so passthrough and the reset
  // blanking both take effect in the same cycle.
  always_comb begin
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = 32'b0;
    mem_wbyte_o = 8'b0;
    stall_req_o = 1'b0;
    wd_o        = 5'b0;
    wreg_o      = 1'b0;
    wdata_o     = 32'b0;
    if (!rst) begin
      wd_o   = wd_i;
      wreg_o = wreg_i;
      case (state)
        IDLE: begin
          if (valid_op)                  stall_req_o = 1'b1;
          else if (!(is_lop || is_sop))  wdata_o     = wdata_i;
        end
        ACCESS: begin
          mem_req_o   = 1'b1;
          mem_we_o    = is_sop;
          mem_addr_o  = mem_addr_i + {30'b0, k};
          mem_wbyte_o = wdata_i[{k, 3'b000} +: 8];
          stall_req_o = 1'b1;
        end
        DONE:    wdata_o = load_ok ? load_res : 32'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_stage_mem.sv
// Self-checking bench for stage_mem: idle/passthrough vector table, directed
// multi-cycle sequences and randomized loads/stores against a byte-memory model.
module tb_stage_mem;

  localparam logic [6:0] L_OP = 7'b0000011;
  localparam logic [6:0] S_OP = 7'b0100011;
  localparam logic [6:0] R_OP = 7'b0110011;
  localparam logic [6:0] I_OP = 7'b0010011;

  logic        clk, rst, rdy;
  logic [6:0]  opcode_i;
  logic [2:0]  func3_i;
  logic [31:0] mem_addr_i, wdata_i;
  logic [4:0]  wd_i;
  logic        wreg_i;
  logic        mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o;
  logic [7:0]  mem_wbyte_o;
  logic        mem_ack_i;
  logic [7:0]  mem_rbyte_i;
  logic        stall_req_o;
  logic [4:0]  wd_o;
  logic        wreg_o;
  logic [31:0] wdata_o;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem [logic [31:0]];

  stage_mem dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .opcode_i(opcode_i), .func3_i(func3_i), .mem_addr_i(mem_addr_i),
    .wdata_i(wdata_i), .wd_i(wd_i), .wreg_i(wreg_i),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wbyte_o(mem_wbyte_o), .mem_ack_i(mem_ack_i), .mem_rbyte_i(mem_rbyte_i),
    .stall_req_o(stall_req_o), .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a[7:0] ^ 8'h5A;
  endfunction

  function automatic int nbytes(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  // RV32I load semantics straight from the byte memory.
  function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] a);
    logic [7:0] b0, b1, b2, b3;
    b0 = rd(a); b1 = rd(a + 32'd1); b2 = rd(a + 32'd2); b3 = rd(a + 32'd3);
    case (f3)
      3'b000:  return {{24{b0[7]}}, b0};
      3'b001:  return {{16{b1[7]}}, b1, b0};
      3'b010:  return {b3, b2, b1, b0};
      3'b100:  return {24'b0, b0};
      3'b101:  return {16'b0, b1, b0};
      default: return 32'b0;
    endcase
  endfunction

  // Runs one memory op acting as the memory controller. Starts and ends at posedge+1.
  // rdy_at >= 0: after that many bytes, rdy is held low 3 cycles with ack high.
  // rst_at >= 0: reset is asserted while requesting that byte, aborting the op.
  task automatic do_op(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] data, input int waits, input int rdy_at,
                       input int rst_at, output logic [31:0] res, output int cycles,
                       output int stalls);
    int seen, wc, rlo;
    bit done;
    logic [31:0] ea;
    seen = 0; wc = 0; rlo = 3; done = 0;
    res = 32'hXXXXXXXX; cycles = 0; stalls = 0;
    opcode_i = op; func3_i = f3; mem_addr_i = addr; wdata_i = data;
    wd_i = 5'd9; wreg_i = (op == L_OP);
    for (int cyc = 0; cyc < 200 && !done; cyc++) begin
      mem_ack_i = 1'b0; rdy = 1'b1; mem_rbyte_i = 8'h00;
      #1;
      cycles++;
      if (stall_req_o) stalls++;
      ea = addr + 32'(seen);
      if (rst_at >= 0 && seen == rst_at && mem_req_o) begin
        rst = 1'b1;
        #1;
        chk("rst_req", mem_req_o, 0);
        chk("rst_stall", stall_req_o, 0);
        chk("rst_addr", mem_addr_o, 0);
        chk("rst_we_wbyte", {mem_we_o, mem_wbyte_o}, 0);
        chk("rst_wd_wreg_wdata", {wd_o, wreg_o, wdata_o}, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("post_rst_idle", {stall_req_o, mem_req_o}, 2'b10);
        opcode_i = R_OP;
        @(posedge clk); #1;
        done = 1;
      end else if (!stall_req_o && cycles > 1) begin
        res = wdata_o;
        chk("done_req", mem_req_o, 0);
        chk("done_wd", {wd_o, wreg_o}, {wd_i, wreg_i});
        @(posedge clk); #1;
        done = 1;
      end else begin
        if (mem_req_o) begin
          chk("acc_we", mem_we_o, op == S_OP);
          chk("acc_addr", mem_addr_o, ea);
          if (op == S_OP) chk("acc_wbyte", mem_wbyte_o, data[8*seen +: 8]);
          if (seen == rdy_at && rlo > 0) begin
            rdy = 1'b0; mem_ack_i = 1'b1; mem_rbyte_i = 8'hEE; rlo--;
          end else if (wc < waits) begin
            wc++;
          end else begin
            mem_ack_i = 1'b1;
            mem_rbyte_i = rd(ea);
            if (op == S_OP) mem[ea] = mem_wbyte_o;
            seen++; wc = 0;
          end
        end else if (cycles > 1) begin
          chk("req_dropped", mem_req_o, 1);
        end
        @(posedge clk); #1;
      end
    end
    mem_ack_i = 1'b0; rdy = 1'b1;
    if (!done) chk("op_timeout", 0, 1);
  endtask

  typedef struct {
    logic        rst;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [31:0] wdata;
    logic [4:0]  wd;
    logic        wreg;
    logic        e_stall;
    logic [31:0] e_wdata;
    logic [4:0]  e_wd;
    logic        e_wreg;
    logic        full;
  } vec_t;

  initial begin
    vec_t vt[8];
    logic [31:0] res, ev;
    int cyc, stl, n, w, ra;
    logic [6:0] op;
    logic [2:0] f3;
    logic [31:0] a, d;

    rst = 1'b1; rdy = 1'b1; opcode_i = R_OP; func3_i = 3'b0; mem_addr_i = 32'b0;
    wdata_i = 32'b0; wd_i = 5'b0; wreg_i = 1'b0; mem_ack_i = 1'b0; mem_rbyte_i = 8'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;

    vt[0] = '{1'b1, L_OP, 3'b010, 32'hDEADBEEF, 5'd7,  1'b1, 1'b0, 32'h0,         5'd0,  1'b0, 1'b1};
    vt[1] = '{1'b0, R_OP, 3'b000, 32'h12345678, 5'd5,  1'b1, 1'b0, 32'h12345678, 5'd5,  1'b1, 1'b1};
    vt[2] = '{1'b0, I_OP, 3'b010, 32'hCAFEF00D, 5'd31, 1'b0, 1'b0, 32'hCAFEF00D, 5'd31, 1'b0, 1'b1};
    vt[3] = '{1'b0, L_OP, 3'b011, 32'h11112222, 5'd3,  1'b1, 1'b0, 32'h0,         5'd3,  1'b1, 1'b1};
    vt[4] = '{1'b0, S_OP, 3'b100, 32'h33334444, 5'd4,  1'b0, 1'b0, 32'h0,         5'd4,  1'b0, 1'b1};
    vt[5] = '{1'b0, L_OP, 3'b110, 32'h55556666, 5'd6,  1'b1, 1'b0, 32'h0,         5'd6,  1'b1, 1'b1};
    vt[6] = '{1'b0, L_OP, 3'b010, 32'h0,        5'd8,  1'b1, 1'b1, 32'h0,         5'd0,  1'b0, 1'b0};
    vt[7] = '{1'b0, S_OP, 3'b000, 32'hAB,       5'd0,  1'b0, 1'b1, 32'h0,         5'd0,  1'b0, 1'b0};

    for (int i = 0; i < 8; i++) begin
      rst = vt[i].rst; opcode_i = vt[i].op; func3_i = vt[i].f3; mem_addr_i = 32'h55;
      wdata_i = vt[i].wdata; wd_i = vt[i].wd; wreg_i = vt[i].wreg;
      #1;
      chk($sformatf("vec%0d_stall", i), stall_req_o, vt[i].e_stall);
      chk($sformatf("vec%0d_mem", i), {mem_req_o, mem_we_o, mem_wbyte_o}, 0);
      chk($sformatf("vec%0d_addr", i), mem_addr_o, 0);
      if (vt[i].full) begin
        chk($sformatf("vec%0d_wdata", i), wdata_o, vt[i].e_wdata);
        chk($sformatf("vec%0d_wd_wreg", i), {wd_o, wreg_o}, {vt[i].e_wd, vt[i].e_wreg});
      end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
    end
    opcode_i = R_OP;

    // LW with acks every cycle
    mem[32'h1000] = 8'h78; mem[32'h1001] = 8'h56; mem[32'h1002] = 8'h34; mem[32'h1003] = 8'h12;
    do_op(L_OP, 3'b010, 32'h1000, 32'h0, 0, -1, -1, res, cyc, stl);
    chk("lw_data", res, 32'h12345678);
    chk("lw_cycles", cyc, 6);
    chk("lw_stalls", stl, 5);

    // Sign vs zero extension
    mem[32'h2003] = 8'h80;
    do_op(L_OP, 3'b000, 32'h2003, 32'h0, 0, -1, -1, res, cyc, stl);
    chk("lb_data", res, 32'hFFFFFF80);
    do_op(L_OP, 3'b100, 32'h2003, 32'h0, 1, -1, -1, res, cyc, stl);
    chk("lbu_data", res, 32'h00000080);
    mem[32'h3000] = 8'h01; mem[32'h3001] = 8'h80;
    do_op(L_OP, 3'b001, 32'h3000, 32'h0, 0, -1, -1, res, cyc, stl);
    chk("lh_data", res, 32'hFFFF8001);

    // SH across the address wrap, two wait cycles per byte
    do_op(S_OP, 3'b001, 32'hFFFFFFFF, 32'h0000BEEF, 2, -1, -1, res, cyc, stl);
    chk("sh_wdata", res, 32'h0);
    chk("sh_cycles", cyc, 8);
    chk("sh_byte0", rd(32'hFFFFFFFF), 8'hEF);
    chk("sh_byte1", rd(32'h00000000), 8'hBE);

    // rdy low after byte 1 with ack held high
    do_op(L_OP, 3'b010, 32'h1000, 32'h0, 0, 1, -1, res, cyc, stl);
    chk("rdy_lw_data", res, 32'h12345678);
    chk("rdy_lw_cycles", cyc, 9);

    // Reset while byte 2 is being requested, then a clean LBU
    do_op(L_OP, 3'b010, 32'h4000, 32'h0, 0, -1, 2, res, cyc, stl);
    mem[32'h5001] = 8'hF0;
    do_op(L_OP, 3'b100, 32'h5001, 32'h0, 0, -1, -1, res, cyc, stl);
    chk("lbu_after_rst", res, 32'h000000F0);
    chk("lbu_after_rst_cycles", cyc, 3);

    // Randomized loads/stores against the byte-memory model
    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(1, 0) == 1) begin
        op = S_OP;
        f3 = 3'($urandom_range(2, 0));
      end else begin
        op = L_OP;
        case ($urandom_range(4, 0))
          0: f3 = 3'b000; 1: f3 = 3'b001; 2: f3 = 3'b010; 3: f3 = 3'b100; default: f3 = 3'b101;
        endcase
      end
      a = ($urandom_range(3, 0) == 0) ? 32'hFFFFFFFC + 32'($urandom_range(3, 0))
                                      : 32'h6000 + 32'($urandom_range(63, 0));
      d = $urandom;
      w = $urandom_range(2, 0);
      n = nbytes(f3);
      ra = ($urandom_range(3, 0) == 0) ? $urandom_range(n - 1, 0) : -1;
      ev = (op == L_OP) ? exp_load(f3, a) : 32'h0;
      do_op(op, f3, a, d, w, ra, -1, res, cyc, stl);
      chk($sformatf("rnd%0d_data", t), res, ev);
      chk($sformatf("rnd%0d_cycles", t), cyc, n + 2 + w * n + ((ra >= 0) ? 3 : 0));
      chk($sformatf("rnd%0d_stalls", t), stl, cyc - 1);
      if (op == S_OP)
        for (int b = 0; b < n; b++)
          chk($sformatf("rnd%0d_mem%0d", t, b), rd(a + 32'(b)), d[8*b +: 8]);
    end

    opcode_i = R_OP;
    @(posedge clk); #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stage_mem.md
# stage_mem

Memory-access pipeline stage: consumes the EX/MEM latch outputs (opcode, func3, effective address, store data, destination register) and performs RV32I loads and stores over a byte-wide request/acknowledge interface to the memory controller. Every access is split into 1, 2 or 4 sequential byte transfers, little-endian. The stage holds the pipeline with `stall_req_o` until the access completes, then presents the sign- or zero-extended load result to MEM/WB. Non-memory instructions pass through combinationally with no stall.

## Interface
- No parameters. Opcodes and func3 values come from the shared defines header:
  - L_OP = 7'b0000011, S_OP = 7'b0100011.
  - LB/SB = 000, LH/SH = 001, LW/SW = 010, LBU = 100, LHU = 101.
- Ports:
  - clk  in  1  system clock; all state changes on the rising edge.
  - rst  in  1  synchronous, active-high reset.
  - rdy  in  1  global ready; when low, the stage freezes.
  - opcode_i  in  7  opcode from EX/MEM.
  - func3_i  in  3  func3 from EX/MEM.
  - mem_addr_i  in  32  effective address.
  - wdata_i  in  32  ALU result, or store data for S_OP.
  - wd_i  in  5  destination register.
  - wreg_i  in  1  register write enable.
  - mem_req_o  out  1  byte-transfer request.
  - mem_we_o  out  1  1 = write byte, 0 = read byte.
  - mem_addr_o  out  32  byte address.
  - mem_wbyte_o  out  8  byte to write.
  - mem_ack_i  in  1  transfer complete, sampled on the edge.
  - mem_rbyte_i  in  8  read byte, valid when mem_ack_i = 1.
  - stall_req_o  out  1  hold IF..MEM stages.
  - wd_o  out  5  to MEM/WB.
  - wreg_o  out  1  to MEM/WB.
  - wdata_o  out  32  to MEM/WB.

## Operation
- **Byte count n:** func3[1:0] = 00 gives 1, 01 gives 2, 10 gives 4.
- **Unknown func3:** any L_OP or S_OP func3 not listed above is treated as a non-memory op. No request, no stall, and wdata_o = 0.
- **FSM states:** IDLE, ACCESS, DONE. Internal state is a 2-bit byte index k and a 32-bit read buffer.
- **IDLE:**
  - With a valid L/S op: stall_req_o = 1. Next state is ACCESS with k = 0 and the buffer cleared.
  - Otherwise: stall_req_o = 0, outputs pass through (wd_o = wd_i, wreg_o = wreg_i, wdata_o = wdata_i).
- **ACCESS:**
  - Drives mem_req_o = 1, mem_we_o = (opcode_i == S_OP), mem_addr_o = mem_addr_i + k (mod 2^32), mem_wbyte_o = wdata_i[8k+7:8k].
  - stall_req_o = 1.
  - On an edge with mem_ack_i = 1: for a load, buffer[8k+7:8k] takes mem_rbyte_i. Then if k == n-1, go to DONE; otherwise k increments.
  - Address, write enable and data stay stable until ack. mem_req_o stays high between bytes of one access.
- **DONE:**
  - mem_req_o = 0, stall_req_o = 0, wd_o = wd_i, wreg_o = wreg_i.
  - Load wdata_o:
    - LB: sign-extend buffer[7:0].
    - LH: sign-extend buffer[15:0].
    - LW: buffer.
    - LBU: zero-extend buffer[7:0].
    - LHU: zero-extend buffer[15:0].
  - Store wdata_o = 0.
  - On an edge with rdy = 1, go to IDLE. This guarantees the same latched instruction is never re-executed.
- **Misaligned addresses** are legal. Byte addresses wrap across 0xFFFFFFFF to 0x00000000.
- **Idle outputs:** whenever not in ACCESS, mem_we_o = 0, mem_addr_o = 0 and mem_wbyte_o = 0.

## Timing
- **Reset:** rst high forces every output to 0. On the edge, state goes to IDLE and k and the buffer are cleared.
  - Reset during ACCESS aborts the access; mem_req_o is low in the same cycle.
  - Bytes already written are not rolled back.
- **rdy = 0:** no state, k or buffer update, and mem_ack_i is ignored. Outputs keep their current combinational values (request held).
- **Latency:** with acks in consecutive cycles, a memory op occupies n+2 cycles: 1 IDLE, n ACCESS, 1 DONE.
  - stall_req_o is high for n+1 cycles.
  - Each ack wait cycle adds one cycle.
- **Non-memory op:** 0 cycles and no stall.
- **Input stability:** the EX/MEM latch holds its outputs while stall_req_o = 1. The stage requires inputs to be stable from IDLE through DONE.

## Test plan
- **Passthrough:** R_OP, wd_i = 5, wreg_i = 1, wdata_i = 0x12345678 -> same values on the outputs in the same cycle, stall_req_o = 0, mem_req_o = 0.
- **LW, immediate acks:** address 0x1000, bytes 0x78/0x56/0x34/0x12 acked each cycle.
  - mem_addr_o steps 0x1000..0x1003.
  - stall_req_o is high for 5 cycles.
  - In DONE, wdata_o = 0x12345678.
- **LB vs LBU:** byte 0x80 at 0x2003 -> LB gives 0xFFFFFF80, LBU gives 0x00000080. LH of 0x8001 gives 0xFFFF8001.
- **SH with 2 wait cycles per byte:** address 0xFFFFFFFF, wdata_i = 0x0000BEEF.
  - Writes 0xEF @ 0xFFFFFFFF, then 0xBE @ 0x00000000.
  - mem_we_o = 1, with address and data stable through the waits.
  - wdata_o = 0 in DONE.
  - Total time: 8 cycles.
- **rdy low mid-LW:** rdy dropped after byte 1 for 3 cycles, with ack held high.
  - No extra byte is captured and no k advance.
  - After rdy returns, the result is correct and the request is held unchanged throughout.
- **Reset mid-LW:** rst asserted at byte 2.
  - All outputs read 0 in that cycle; state is IDLE next.
  - A following LBU completes normally.
